zigzag_scan_ctrl: RTL and testbench

- Sequencer for the 3x3 convolution window's serpentine scan over a C x R feature map.
- Per accepted input beat it issues one shift command to the window register array: load, right, left or down.
- It also issues push/pop commands to the two column-reuse stacks (stack A and stack B), so pixels pushed on one sweep direction are popped on the reverse sweep.
- Sits between the input fetch unit and the register array / reuse-stack datapath.

---
 rtl/scan_pkg.sv | 28 ++
 rtl/scan_pos_cnt.sv | 56 +++++
 rtl/zigzag_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_zigzag_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the zigzag (serpentine) 3x3 window scan controller:
// state codes, shift-command encodings, reuse-stack bit indices and defaults.
package scan_pkg;

  localparam int DIM_W_DEF = 9;
  localparam int KSZ_DEF   = 3;

  // Scan states, kept as plain codes so older tools can consume them too.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FIRST   = 3'd1;
  localparam state_t ST_PAUSE   = 3'd2;
  localparam state_t ST_SWEEP_L = 3'd3;
  localparam state_t ST_SWEEP_R = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

  // Window register-array shift commands.
  typedef logic [1:0] cmd_t;
  localparam cmd_t CMD_LOAD  = 2'd0;
  localparam cmd_t CMD_RIGHT = 2'd1;
  localparam cmd_t CMD_LEFT  = 2'd2;
  localparam cmd_t CMD_DOWN  = 2'd3;

  // Bit positions in stk_push / stk_pop.
  localparam int STK_A = 0;
  localparam int STK_B = 1;

endpackage

// File: rtl/scan_pos_cnt.sv
// Window position counters: column counts up/down/holds within a band and
// the row counts bands. The flags are evaluated on the post-update value, so
// the controller can decide the next state in the same cycle as the beat.
module scan_pos_cnt #(
  parameter int DIM_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             col_inc,
  input  logic             col_dec,
  input  logic             row_inc,
  input  logic [DIM_W-1:0] col_last,
  input  logic [DIM_W-1:0] row_last,
  output logic [DIM_W-1:0] col,
  output logic [DIM_W-1:0] row,
  output logic             col_at_end,
  output logic             col_at_zero,
  output logic             row_at_last
);

  localparam logic [DIM_W-1:0] ONE = 1;

  logic [DIM_W-1:0] col_nxt;
  logic [DIM_W-1:0] row_nxt;

  // Next-position arithmetic; clear wins so a new scan always starts at (0,0).
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (clr) begin
      col_nxt = '0;
      row_nxt = '0;
    end else begin
      if (col_inc)      col_nxt = col + ONE;
      else if (col_dec) col_nxt = col - ONE;
      if (row_inc)      row_nxt = row + ONE;
    end
  end

  assign col_at_end  = (col_nxt == col_last);
  assign col_at_zero = (col_nxt == '0);
  assign row_at_last = (row_nxt == row_last);

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

endmodule

// File: rtl/zigzag_scan_ctrl.sv
// Serpentine scan sequencer for a 3x3 convolution window over a C x R map.
// Issues one shift command per accepted beat plus push/pop commands to the
// two column-reuse stacks so each band reuses the previous band's pixels.
// Optional build macro: SCAN_PERF_CNT_EN adds the stall_cnt output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; cfg checked and latched here
// FIRST    | first band, LOAD then RIGHT moves, pushes stack A
// PAUSE    | single DOWN beat between bands, pops the last band's stack
// SWEEP_L  | band moving left: LEFT, push B, pop A
// SWEEP_R  | band moving right: RIGHT, push A, pop B
// DONE     | one-cycle completion, done pulse
module zigzag_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF,
  parameter int KSZ   = KSZ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] cfg_col,
  input  logic [DIM_W-1:0] cfg_row,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       sh_cmd,
  output logic             sh_vld,
  output logic [1:0]       stk_push,
  output logic [1:0]       stk_pop,
  output logic [DIM_W-1:0] win_col,
  output logic [DIM_W-1:0] win_row,
  output logic             busy,
  output logic             done,
`ifdef SCAN_PERF_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             cfg_err
);

  if (KSZ != 3) begin : g_bad_ksz
    $error("zigzag_scan_ctrl: KSZ must be 3");
  end

  localparam logic [DIM_W-1:0] KMIN = DIM_W'(KSZ);

  state_t           state, state_nxt;
  logic [DIM_W-1:0] col_cfg, row_cfg;
  logic [DIM_W-1:0] p_last, b_last;
  logic             loaded, dir_left;
  logic             scan_st, beat, start_ok, start_bad;
  logic             col_inc, col_dec, row_inc;
  logic             col_at_end, col_at_zero, row_at_last;
  cmd_t             cmd;
  logic [1:0]       push, pop;

  // Last column / last band index: P-1 = C-3 and B-1 = R-3.
  assign p_last = col_cfg - KMIN;
  assign b_last = row_cfg - KMIN;

  assign scan_st   = (state == ST_FIRST) || (state == ST_PAUSE) ||
                     (state == ST_SWEEP_L) || (state == ST_SWEEP_R);
  // Abort kills the handshake too, so an aborted beat never issues a command.
  assign in_ready  = scan_st && !abort;
  assign beat      = in_valid && in_ready;
  assign start_ok  = (state == ST_IDLE) && start && (cfg_col >= KMIN) && (cfg_row >= KMIN);
  assign start_bad = (state == ST_IDLE) && start && !((cfg_col >= KMIN) && (cfg_row >= KMIN));

  scan_pos_cnt #(.DIM_W(DIM_W)) u_pos (
    .clk         (clk),
    .rst         (rst),
    .clr         (start_ok),
    .col_inc     (col_inc),
    .col_dec     (col_dec),
    .row_inc     (row_inc),
    .col_last    (p_last),
    .row_last    (b_last),
    .col         (win_col),
    .row         (win_row),
    .col_at_end  (col_at_end),
    .col_at_zero (col_at_zero),
    .row_at_last (row_at_last)
  );

  // Command decode and next-state selection from state and accepted beat.
  always_comb begin
    state_nxt = state;
    cmd       = CMD_LOAD;
    push      = 2'b00;
    pop       = 2'b00;
    col_inc   = 1'b0;
    col_dec   = 1'b0;
    row_inc   = 1'b0;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_FIRST;
      ST_FIRST: if (beat) begin
        push[STK_A] = 1'b1;
        if (loaded) begin
          cmd     = CMD_RIGHT;
          col_inc = 1'b1;
        end
        if (col_at_end) state_nxt = (b_last == '0) ? ST_DONE : ST_PAUSE;
      end
      ST_PAUSE: if (beat) begin
        cmd     = CMD_DOWN;
        row_inc = 1'b1;
        if (dir_left) pop[STK_B] = 1'b1;
        else          pop[STK_A] = 1'b1;
        // With a single position per band every band is just one DOWN.
        if (p_last == '0) state_nxt = row_at_last ? ST_DONE : ST_PAUSE;
        else              state_nxt = dir_left ? ST_SWEEP_R : ST_SWEEP_L;
      end
      ST_SWEEP_L: if (beat) begin
        cmd         = CMD_LEFT;
        col_dec     = 1'b1;
        push[STK_B] = 1'b1;
        pop[STK_A]  = 1'b1;
        if (col_at_zero) state_nxt = row_at_last ? ST_DONE : ST_PAUSE;
      end
      ST_SWEEP_R: if (beat) begin
        cmd         = CMD_RIGHT;
        col_inc     = 1'b1;
        push[STK_A] = 1'b1;
        pop[STK_B]  = 1'b1;
        if (col_at_end) state_nxt = row_at_last ? ST_DONE : ST_PAUSE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
  end

  assign sh_vld   = beat;
  assign sh_cmd   = cmd;
  assign stk_push = push;
  assign stk_pop  = pop;
  assign busy     = scan_st;
  assign done     = (state == ST_DONE);

  // State, latched geometry and band-direction tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      col_cfg  <= '0;
      row_cfg  <= '0;
      loaded   <= 1'b0;
      dir_left <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= start_bad;
      if (start_ok) begin
        col_cfg  <= cfg_col;
        row_cfg  <= cfg_row;
        loaded   <= 1'b0;
        dir_left <= 1'b0;
      end else if (beat) begin
        loaded <= 1'b1;
        // dir_left tracks the direction of the band that follows each DOWN.
        if (state == ST_PAUSE) dir_left <= !dir_left;
      end
    end
  end

`ifdef SCAN_PERF_CNT_EN
  // Saturating count of scan cycles starved by the fetch unit.
  always_ff @(posedge clk) begin
    if (rst)                                                   stall_cnt <= '0;
    else if (start_ok)                                         stall_cnt <= '0;
    else if (scan_st && !in_valid && (stall_cnt != 16'hFFFF))  stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_zigzag_scan_ctrl.sv
// Self-checking bench for zigzag_scan_ctrl: a band-by-band reference model
// fills a scoreboard queue at scan start; beats pop and compare it.
module tb_zigzag_scan_ctrl;

  logic       clk, rst, start, abort, in_valid;
  logic [8:0] cfg_col, cfg_row;
  logic       in_ready, sh_vld, busy, done, cfg_err;
  logic [1:0] sh_cmd, stk_push, stk_pop;
  logic [8:0] win_col, win_row;
`ifdef SCAN_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  zigzag_scan_ctrl #(.DIM_W(9), .KSZ(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_col(cfg_col), .cfg_row(cfg_row),
    .in_valid(in_valid), .in_ready(in_ready),
    .sh_cmd(sh_cmd), .sh_vld(sh_vld), .stk_push(stk_push), .stk_pop(stk_pop),
    .win_col(win_col), .win_row(win_row), .busy(busy), .done(done),
`ifdef SCAN_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    logic [1:0] push;
    logic [1:0] pop;
    logic [8:0] col;
    logic [8:0] row;
  } exp_t;

  typedef struct {
    int c;
    int r;
    bit toggle;
    int beats;
    int end_col;
    int end_row;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference scan order: band 0 moves right from a LOAD; each later band
  // starts with a DOWN popping the previous band's stack, then moves the
  // opposite way pushing its own stack and popping the other.
  task automatic build_model(input int c, input int r);
    int   p, nb, col;
    bit   left;
    exp_t e;
    p  = c - 2;
    nb = r - 2;
    col = 0;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      left = (b % 2) == 1;
      for (int i = 0; i < p; i++) begin
        if (b == 0) begin
          col    = i;
          e.cmd  = (i == 0) ? 2'd0 : 2'd1;
          e.push = 2'b01;
          e.pop  = 2'b00;
        end else if (i == 0) begin
          e.cmd  = 2'd3;
          e.push = 2'b00;
          e.pop  = left ? 2'b01 : 2'b10;
        end else if (left) begin
          col    = col - 1;
          e.cmd  = 2'd2;
          e.push = 2'b10;
          e.pop  = 2'b01;
        end else begin
          col    = col + 1;
          e.cmd  = 2'd1;
          e.push = 2'b01;
          e.pop  = 2'b10;
        end
        e.col = 9'(col);
        e.row = 9'(b);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 of the first scan cycle.
  task automatic do_start(input int c, input int r);
    cfg_col = 9'(c);
    cfg_row = 9'(r);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // One scan cycle with in_valid = v; compares the beat with the scoreboard.
  task automatic cycle(input bit v, output bit got);
    logic [8:0] pc, pr;
    exp_t e;
    got = 1'b0;
    in_valid = v;
    pc = win_col;
    pr = win_row;
    @(negedge clk);
    chk("in_ready", in_ready, 1);
    chk("sh_vld", sh_vld, v);
    if (v) begin
      if (exp_q.size() == 0) fail_now("extra_beat");
      else begin
        e = exp_q.pop_front();
        got = 1'b1;
        chk("sh_cmd", sh_cmd, e.cmd);
        chk("stk_push", stk_push, e.push);
        chk("stk_pop", stk_pop, e.pop);
      end
    end else begin
      chk("stall_push", stk_push, 0);
      chk("stall_pop", stk_pop, 0);
    end
    @(posedge clk); #1;
    if (got) begin
      chk("win_col", win_col, e.col);
      chk("win_row", win_row, e.row);
    end else begin
      chk("hold_col", win_col, pc);
      chk("hold_row", win_row, pr);
    end
  endtask

  task automatic run_scan(input vec_t v);
    int beats, k;
    bit got;
    build_model(v.c, v.r);
    do_start(v.c, v.r);
    chk("busy_start", busy, 1);
    chk("pos_start", {win_col, win_row}, 0);
    beats = 0;
    k = 0;
    while (!done && k < 300) begin
      cycle(v.toggle ? (k % 2 == 0) : 1'b1, got);
      if (got) beats++;
      k++;
    end
    in_valid = 1'b0;
    if (!done) fail_now("done_timeout");
    else begin
      chk("beat_count", beats, v.beats);
      chk("sb_empty", exp_q.size(), 0);
      chk("done_busy", busy, 0);
      chk("done_ready", in_ready, 0);
      chk("end_col", win_col, v.end_col);
      chk("end_row", win_row, v.end_row);
`ifdef SCAN_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, v.toggle ? v.beats - 1 : 0);
`endif
      @(posedge clk); #1;
      chk("done_pulse_end", done, 0);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    vec_t v;
    vecs[0] = '{c: 5,  r: 5, toggle: 1'b0, beats: 9,  end_col: 2, end_row: 2};
    vecs[1] = '{c: 5,  r: 5, toggle: 1'b1, beats: 9,  end_col: 2, end_row: 2};
    vecs[2] = '{c: 3,  r: 5, toggle: 1'b0, beats: 3,  end_col: 0, end_row: 2};
    vecs[3] = '{c: 10, r: 3, toggle: 1'b0, beats: 8,  end_col: 7, end_row: 0};
    vecs[4] = '{c: 6,  r: 6, toggle: 1'b0, beats: 16, end_col: 0, end_row: 3};
    vecs[5] = '{c: 4,  r: 7, toggle: 1'b1, beats: 10, end_col: 1, end_row: 4};

    // Reset with start held high: nothing may start.
    rst = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1;
    cfg_col = 9'd5; cfg_row = 9'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vld", sh_vld, 0);
    chk("rst_stk", {stk_push, stk_pop}, 0);
    chk("rst_pos", {win_col, win_row}, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // Illegal geometry: one-cycle cfg_err, scan never starts.
    do_start(2, 8);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_err_busy", busy, 0);
    chk("cfg_err_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_err_busy2", busy, 0);
    do_start(8, 2);
    chk("cfg_err_row", cfg_err, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_scan(vecs[i]);

    // Abort on the 6th beat of a 6x6 scan.
    build_model(6, 6);
    do_start(6, 6);
    for (int i = 0; i < 5; i++) cycle(1'b1, got);
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_vld", sh_vld, 0);
    chk("abort_stk", {stk_push, stk_pop}, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_col_held", win_col, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
    end
    v = vecs[4];
    run_scan(v);

    // Reset in the middle of the first left sweep, start held during reset.
    build_model(6, 6);
    do_start(6, 6);
    for (int i = 0; i < 6; i++) cycle(1'b1, got);
    chk("pre_rst_col", win_col, 2);
    in_valid = 1'b1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready", in_ready, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_vld", sh_vld, 0);
    chk("mrst_stk", {stk_push, stk_pop}, 0);
    chk("mrst_pos", {win_col, win_row}, 0);
    chk("mrst_cfg_err", cfg_err, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("mrst_idle", busy, 0);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
